mem_arbiter: RTL

- Single-port arbiter/sequencer sharing the unified memory between the instruction-fetch requester and the load/store requester.
- Decodes each word address into one of two regions:
  - on-chip SRAM: synchronous, 1-cycle read latency.
  - external LPDDR2 bridge: variable latency, req/ready handshake.
- Returns read data and a one-cycle ack to the granted requester.
- Sits between the CPU core (fetch/memory stages) and the SRAM/LPDDR2 blocks.

---
 rtl/mem_arbiter_pkg.sv | 27 ++
 rtl/mem_arbiter_rr.sv | 36 +++
 rtl/mem_arbiter.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the unified-memory arbiter: FSM state encoding,
// grant ids and default region widths used by the SRAM and bridge instances.
package mem_arbiter_pkg;

    localparam int DEF_SRAM_AW = 12;
    localparam int DEF_EXT_AW  = 27;
    localparam int DEF_TIMEOUT = 1023;
    localparam int ADDR_W      = 30;
    localparam int DATA_W      = 32;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SRAM_ACC = 3'd1,
        SRAM_RD  = 3'd2,
        EXT      = 3'd3,
        RESP     = 3'd4
    } state_t;

    localparam logic GNT_IF = 1'b0;
    localparam logic GNT_D  = 1'b1;

    // True when the word address falls inside the on-chip SRAM window.
    function automatic logic in_sram(input logic [ADDR_W-1:0] addr, input int aw);
        return (addr >> aw) == '0;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr.sv
// rr_arbiter2: two-way round-robin grant between fetch and data; the pointer
// remembers the last requester served and resets so the first tie goes to data.
module rr_arbiter2
    import mem_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_if,
    input  logic req_d,
    input  logic update,
    input  logic update_id,
    output logic gnt_valid,
    output logic gnt_id
);

    logic last_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= GNT_IF;
        end else if (update) begin
            last_q <= update_id;
        end
    end

    always_comb begin
        gnt_valid = req_if | req_d;
        gnt_id    = GNT_IF;
        if (req_if && req_d) begin
            gnt_id = (last_q == GNT_D) ? GNT_IF : GNT_D;
        end else if (req_d) begin
            gnt_id = GNT_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port sequencer sharing unified memory between fetch and load/store,
// routing to on-chip SRAM or the LPDDR2 bridge. MEM_TIMEOUT_EN adds a bridge timeout.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int SRAM_AW = DEF_SRAM_AW,
    parameter int EXT_AW  = DEF_EXT_AW,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               if_req,
    input  logic [29:0]        if_addr,
    output logic [31:0]        if_rdata,
    output logic               if_ack,
    input  logic               d_req,
    input  logic               d_we,
    input  logic [29:0]        d_addr,
    input  logic [31:0]        d_wdata,
    output logic [31:0]        d_rdata,
    output logic               d_ack,
    output logic [SRAM_AW-1:0] sram_address,
    output logic [31:0]        sram_data,
    output logic               sram_wren,
    input  logic [31:0]        sram_q,
    output logic [EXT_AW-1:0]  ext_address,
    output logic [31:0]        ext_write_data,
    output logic               ext_read_req,
    output logic               ext_write_req,
    input  logic [31:0]        ext_read_data,
    input  logic               ext_ready,
    output logic               bus_err,
    output state_t             dbg_state
);

    // Handshake: a requester holds req/addr/we/wdata stable until its one-cycle
    // ack; the bridge holds nothing, we keep ext_*_req high until ext_ready.
    localparam logic [EXT_AW-1:0] EXT_BASE = EXT_AW'(2**SRAM_AW);

    state_t              state_q, state_d;
    logic [EXT_AW-1:0]   addr_q;
    logic                we_q;
    logic [31:0]         wdata_q;
    logic                gnt_q;
    logic [31:0]         if_rdata_q, d_rdata_q;
    logic                gnt_valid, gnt_id;
    logic [29:0]         sel_addr;
    logic                load, capture, timeout_hit;
    logic [31:0]         cap_data;

    rr_arbiter2 u_rr (
        .clk       (clk),
        .rst       (rst),
        .req_if    (if_req),
        .req_d     (d_req),
        .update    (state_q == RESP),
        .update_id (gnt_q),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    assign sel_addr = (gnt_id == GNT_D) ? d_addr : if_addr;

    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        capture  = 1'b0;
        cap_data = '0;
        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    load    = 1'b1;
                    state_d = in_sram(sel_addr, SRAM_AW) ? SRAM_ACC : EXT;
                end
            end
            SRAM_ACC: state_d = SRAM_RD;
            SRAM_RD: begin
                capture  = 1'b1;
                cap_data = sram_q;
                state_d  = RESP;
            end
            EXT: begin
                if (ext_ready) begin
                    capture  = 1'b1;
                    cap_data = we_q ? 32'h0 : ext_read_data;
                    state_d  = RESP;
                end else if (timeout_hit) begin
                    capture = 1'b1;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            gnt_q      <= GNT_IF;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                // Fetches are always reads and carry no write data.
                addr_q  <= sel_addr[EXT_AW-1:0];
                gnt_q   <= gnt_id;
                we_q    <= (gnt_id == GNT_D) && d_we;
                wdata_q <= (gnt_id == GNT_D) ? d_wdata : '0;
            end
            if (capture) begin
                if (gnt_q == GNT_D) begin
                    d_rdata_q <= cap_data;
                end else begin
                    if_rdata_q <= cap_data;
                end
            end
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] to_cnt_q;
    logic          err_q;

    assign timeout_hit = (state_q == EXT) && !ext_ready && (to_cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            to_cnt_q <= (state_q == EXT) ? to_cnt_q + 1'b1 : '0;
            if (state_q == IDLE) begin
                err_q <= 1'b0;
            end else if (timeout_hit) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus_err = (state_q == RESP) && err_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
    assign timeout_hit    = 1'b0;
    assign bus_err        = 1'b0;
`endif

    assign sram_address   = (state_q == SRAM_ACC || state_q == SRAM_RD) ? addr_q[SRAM_AW-1:0] : '0;
    assign sram_wren      = (state_q == SRAM_ACC) && we_q;
    assign sram_data      = (state_q == SRAM_ACC) ? wdata_q : '0;

    // Upper-region offset wraps modulo 2**EXT_AW by construction of the width.
    assign ext_address    = (state_q == EXT) ? (addr_q - EXT_BASE) : '0;
    assign ext_read_req   = (state_q == EXT) && !we_q;
    assign ext_write_req  = (state_q == EXT) && we_q;
    assign ext_write_data = (state_q == EXT && we_q) ? wdata_q : '0;

    assign if_ack    = (state_q == RESP) && (gnt_q == GNT_IF);
    assign d_ack     = (state_q == RESP) && (gnt_q == GNT_D);
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign dbg_state = state_q;

endmodule
